// File: rtl/acc_dp_pkg.sv
// Shared types and constants for the second-generation accumulator datapath.
// Used by acc_alu_g2 and acc_datapath_g2.
package acc_dp_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SHL   = 3'd5,
    ALU_SHR   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NEG    = 2'b00,
    BR_ZERO   = 2'b01,
    BR_CARRY  = 2'b10,
    BR_ALWAYS = 2'b11
  } br_cond_e;

  // Instruction class after priority decode of the mutually exclusive strobes
  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_LD  = 2'd1,
    CLS_ST  = 2'd2,
    CLS_BR  = 2'd3
  } instr_cls_e;

  localparam int R_OUT = 0;
  localparam int R_IN  = 1;

  function automatic instr_cls_e decode_cls(input logic is_br, input logic is_st,
                                            input logic is_ld);
    if (is_br)      return CLS_BR;
    else if (is_st) return CLS_ST;
    else if (is_ld) return CLS_LD;
    else            return CLS_ALU;
  endfunction

endpackage

// File: rtl/acc_alu_g2.sv
// Combinational ALU for acc_datapath_g2: result plus carry-out.
// Ops that do not define a carry pass c_in through, so the caller can load it
// unconditionally on every completed ALU instruction.
module acc_alu_g2
  import acc_dp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  input  logic              c_in,
  output logic [DATA_W-1:0] y,
  output logic              c_out
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // diff carry is set when no borrow occurred (a >= b unsigned)
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);

  // Operation select
  always_comb begin
    y     = '0;
    c_out = c_in;
    unique case (op)
      ALU_ADD:   begin y = sum[DATA_W-1:0];  c_out = sum[DATA_W];  end
      ALU_SUB:   begin y = diff[DATA_W-1:0]; c_out = diff[DATA_W]; end
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SHL:   begin y = {a[DATA_W-2:0], 1'b0}; c_out = a[DATA_W-1]; end
      ALU_SHR:   begin y = {1'b0, a[DATA_W-1:1]}; c_out = a[0];        end
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/acc_datapath_g2.sv
// Second-generation accumulator datapath: PC, accumulator A, optional carry,
// register file with r0 as output port and r1 as handshaked input port.
// Optional carry flag is built when ACC_DP_CARRY_EN is defined.
module acc_datapath_g2
  import acc_dp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 7,
  parameter int NREG   = 4,
  parameter int RID_W  = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RSTN,
  output logic [PC_W-1:0]   PC,
  input  logic [DATA_W-1:0] IPORT_DATA,
  input  logic              IPORT_VALID,
  output logic              IPORT_READY,
  output logic [DATA_W-1:0] OPORT,
  output logic              OPORT_STB,
  input  logic [2:0]        ALU_OP,
  input  logic [DATA_W-1:0] INSTR_IMM,
  input  logic              IMM_SEL,
  input  logic [PC_W-1:0]   BR_TARGET,
  input  logic              IS_BR,
  input  logic [1:0]        BR_COND,
  input  logic              IS_LD,
  input  logic              LD_SEL,
  input  logic [DATA_W-1:0] LB_IMM,
  input  logic              IS_ST,
  input  logic [RID_W-1:0]  REG_ID,
  output logic              STALL,
  output logic [2:0]        FLAGS
);

  logic [PC_W-1:0]              pc_q;
  logic [DATA_W-1:0]            a_q;
  logic [NREG-1:0][DATA_W-1:0]  rf;
  logic                         stb_q;

  instr_cls_e        cls;
  logic              sel_in;
  logic              reads_in;
  logic              stall;
  logic              advance;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic              c_flag;
  logic              n_flag;
  logic              z_flag;
  logic              br_taken;

  assign cls    = decode_cls(IS_BR, IS_ST, IS_LD);
  assign sel_in = (REG_ID == RID_W'(R_IN));

  // r1 is not backed by storage: reads see the input port directly
  assign rd_data = sel_in ? IPORT_DATA : rf[REG_ID];

  assign reads_in = sel_in && (((cls == CLS_LD)  && !LD_SEL) ||
                               ((cls == CLS_ALU) && !IMM_SEL));

  // Reset dominates the handshake so nothing is consumed while held in reset
  assign stall       = RSTN && reads_in && !IPORT_VALID;
  assign IPORT_READY = RSTN && reads_in &&  IPORT_VALID;
  assign advance     = RSTN && !stall;
  assign STALL       = stall;

  assign alu_b = IMM_SEL ? INSTR_IMM : rd_data;

  acc_alu_g2 #(.DATA_W(DATA_W)) u_alu (
    .a     (a_q),
    .b     (alu_b),
    .op    (alu_op_e'(ALU_OP)),
    .c_in  (c_flag),
    .y     (alu_y),
    .c_out (alu_c)
  );

`ifdef ACC_DP_CARRY_EN
  logic c_q;

  // Carry only moves on completed ALU instructions
  always_ff @(posedge CLK) begin
    if (!RSTN)                         c_q <= 1'b0;
    else if (advance && cls == CLS_ALU) c_q <= alu_c;
  end

  assign c_flag = c_q;
`else
  logic unused_carry;
  assign unused_carry = alu_c;
  assign c_flag       = 1'b0;
`endif

  assign n_flag = a_q[DATA_W-1];
  assign z_flag = (a_q == '0);
  assign FLAGS  = {c_flag, z_flag, n_flag};

  // Branch condition from pre-cycle flags
  always_comb begin
    br_taken = 1'b0;
    unique case (br_cond_e'(BR_COND))
      BR_NEG:    br_taken = n_flag;
      BR_ZERO:   br_taken = z_flag;
      BR_CARRY:  br_taken = c_flag;
      BR_ALWAYS: br_taken = 1'b1;
      default:   br_taken = 1'b0;
    endcase
  end

  // Program counter: branch target or sequential increment (wraps naturally)
  always_ff @(posedge CLK) begin
    if (!RSTN)
      pc_q <= '0;
    else if (advance)
      pc_q <= (cls == CLS_BR && br_taken) ? BR_TARGET : pc_q + PC_W'(1);
  end

  // Accumulator: loads and ALU results
  always_ff @(posedge CLK) begin
    if (!RSTN)
      a_q <= '0;
    else if (advance) begin
      if (cls == CLS_LD)       a_q <= LD_SEL ? LB_IMM : rd_data;
      else if (cls == CLS_ALU) a_q <= alu_y;
    end
  end

  // Register file: stores of A, writes to the input-port slot are dropped
  always_ff @(posedge CLK) begin
    if (!RSTN)
      rf <= '0;
    else if (advance && cls == CLS_ST && !sel_in)
      rf[REG_ID] <= a_q;
  end

  // Output strobe lines up with the cycle OPORT shows the stored value
  always_ff @(posedge CLK) begin
    if (!RSTN) stb_q <= 1'b0;
    else       stb_q <= advance && cls == CLS_ST && (REG_ID == RID_W'(R_OUT));
  end

  assign PC        = pc_q;
  assign OPORT     = rf[R_OUT];
  assign OPORT_STB = stb_q;

endmodule

// File: tb/tb_acc_datapath_g2.sv
// Self-checking bench for acc_datapath_g2: directed steps followed by random
// instructions, all checked against an instruction-level reference model.
module tb_acc_datapath_g2;
  import acc_dp_pkg::*;

  localparam int DW = 8;
  localparam int PW = 7;
  localparam int NR = 4;
  localparam int RW = 2;
`ifdef ACC_DP_CARRY_EN
  localparam bit HAS_C = 1'b1;
`else
  localparam bit HAS_C = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic [PW-1:0] PC;
  logic [DW-1:0] IPORT_DATA = '0;
  logic          IPORT_VALID = 1'b0;
  logic          IPORT_READY;
  logic [DW-1:0] OPORT;
  logic          OPORT_STB;
  logic [2:0]    ALU_OP = '0;
  logic [DW-1:0] INSTR_IMM = '0;
  logic          IMM_SEL = 1'b1;
  logic [PW-1:0] BR_TARGET = '0;
  logic          IS_BR = 1'b0;
  logic [1:0]    BR_COND = '0;
  logic          IS_LD = 1'b0;
  logic          LD_SEL = 1'b1;
  logic [DW-1:0] LB_IMM = '0;
  logic          IS_ST = 1'b0;
  logic [RW-1:0] REG_ID = '0;
  logic          STALL;
  logic [2:0]    FLAGS;

  always #5 CLK = ~CLK;

  acc_datapath_g2 dut (
    .CLK(CLK), .RSTN(RSTN), .PC(PC),
    .IPORT_DATA(IPORT_DATA), .IPORT_VALID(IPORT_VALID), .IPORT_READY(IPORT_READY),
    .OPORT(OPORT), .OPORT_STB(OPORT_STB),
    .ALU_OP(ALU_OP), .INSTR_IMM(INSTR_IMM), .IMM_SEL(IMM_SEL),
    .BR_TARGET(BR_TARGET), .IS_BR(IS_BR), .BR_COND(BR_COND),
    .IS_LD(IS_LD), .LD_SEL(LD_SEL), .LB_IMM(LB_IMM),
    .IS_ST(IS_ST), .REG_ID(REG_ID), .STALL(STALL), .FLAGS(FLAGS)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (instruction-level)
  int m_a = 0, m_c = 0, m_pc = 0, m_stb = 0;
  int m_reg[NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshake mid-cycle, advance model, check state after edge
  task automatic cycle();
    bit alu_cls, rd1, e_stall, e_ready, tk;
    int rd, b, r, nc, flg;
    alu_cls = !IS_BR && !IS_ST && !IS_LD;
    rd1     = (REG_ID == 1) && ((IS_LD && !LD_SEL) || (alu_cls && !IMM_SEL));
    e_stall = RSTN && rd1 && !IPORT_VALID;
    e_ready = RSTN && rd1 && IPORT_VALID;
    @(negedge CLK);
    chk("stall", 32'(STALL), 32'(e_stall));
    chk("iport_ready", 32'(IPORT_READY), 32'(e_ready));
    if (!RSTN) begin
      m_a = 0; m_c = 0; m_pc = 0; m_stb = 0;
      for (int i = 0; i < NR; i++) m_reg[i] = 0;
    end else if (e_stall) begin
      m_stb = 0;
    end else begin
      rd    = (REG_ID == 1) ? int'(IPORT_DATA) : m_reg[REG_ID];
      m_stb = 0;
      tk    = 1'b0;
      if (IS_BR) begin
        case (BR_COND)
          2'd0: tk = (m_a >= 128);
          2'd1: tk = (m_a == 0);
          2'd2: tk = HAS_C && (m_c != 0);
          default: tk = 1'b1;
        endcase
      end
      m_pc = tk ? int'(BR_TARGET) : (m_pc + 1) % (1 << PW);
      if (IS_BR) begin
        // flags and data untouched
      end else if (IS_ST) begin
        if (REG_ID != 1) m_reg[REG_ID] = m_a;
        m_stb = (REG_ID == 0);
      end else if (IS_LD) begin
        m_a = LD_SEL ? int'(LB_IMM) : rd;
      end else begin
        b  = IMM_SEL ? int'(INSTR_IMM) : rd;
        nc = m_c;
        case (ALU_OP)
          3'd0: begin r = m_a + b; nc = (r > 255); end
          3'd1: begin r = m_a - b; nc = (m_a >= b); end
          3'd2: r = m_a & b;
          3'd3: r = m_a | b;
          3'd4: r = m_a ^ b;
          3'd5: begin r = m_a * 2; nc = (m_a >= 128); end
          3'd6: begin r = m_a / 2; nc = m_a % 2; end
          default: r = b;
        endcase
        m_a = r & 255;
        if (HAS_C) m_c = nc;
      end
    end
    @(posedge CLK);
    #1;
    flg = ((HAS_C ? m_c : 0) << 2) | ((m_a == 0) << 1) | (m_a >= 128 ? 1 : 0);
    chk("pc", 32'(PC), 32'(m_pc));
    chk("flags", 32'(FLAGS), 32'(flg));
    chk("oport", 32'(OPORT), 32'(m_reg[0]));
    chk("oport_stb", 32'(OPORT_STB), 32'(m_stb));
  endtask

  task automatic clr();
    IS_BR = 0; IS_ST = 0; IS_LD = 0; IMM_SEL = 1; LD_SEL = 1;
    REG_ID = '0; ALU_OP = '0; INSTR_IMM = '0; LB_IMM = '0; BR_COND = '0; BR_TARGET = '0;
  endtask

  task automatic t_ldi(input int v);
    clr(); IS_LD = 1; LB_IMM = DW'(v); cycle();
  endtask

  task automatic t_alui(input int op, input int v);
    clr(); ALU_OP = 3'(op); INSTR_IMM = DW'(v); cycle();
  endtask

  task automatic t_alur(input int op, input int rid);
    clr(); ALU_OP = 3'(op); IMM_SEL = 0; REG_ID = RW'(rid); cycle();
  endtask

  task automatic t_st(input int rid);
    clr(); IS_ST = 1; REG_ID = RW'(rid); cycle();
  endtask

  task automatic t_br(input int cond, input int tgt);
    clr(); IS_BR = 1; BR_COND = 2'(cond); BR_TARGET = PW'(tgt); cycle();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_reg[i] = 0;
    clr();

    // Reset held two cycles
    RSTN = 0; cycle(); cycle();
    chk("reset_flags", 32'(FLAGS), 32'(3'b010));
    RSTN = 1;

    // Arithmetic with carry, then carry branch
    t_ldi(8'hF0);
    t_alui(0, 8'h20);
    t_st(0);
    t_br(2, 7'h55);

    // Input stall for three cycles, then data arrives
    IPORT_VALID = 0; IPORT_DATA = 8'h05;
    t_alur(0, 1); t_alur(0, 1); t_alur(0, 1);
    IPORT_VALID = 1;
    t_alur(0, 1);
    t_st(0);

    // Output strobe and r1 write protection
    t_ldi(8'h5A); t_st(0); t_ldi(8'h11); t_st(2); t_st(1);
    IPORT_DATA = 8'h33;
    clr(); IS_LD = 1; LD_SEL = 0; REG_ID = 1; cycle();
    t_st(0);
    t_alur(3, 2); t_st(0);

    // Remaining ALU ops
    t_ldi(8'h81); t_alui(5, 0); t_alui(6, 0); t_alui(1, 8'h50);
    t_alui(1, 8'h01); t_alui(4, 8'hFF); t_alui(2, 8'h0F); t_alui(7, 8'hC3); t_st(0);

    // Branch conditions and PC wrap
    t_ldi(0); t_br(1, 10);
    t_ldi(8'h80); t_br(0, 20);
    t_ldi(8'h01); t_br(0, 30);
    t_br(3, 127);
    t_br(1, 5);

    // Reset asserted while stalled
    IPORT_VALID = 0;
    t_alur(0, 1);
    RSTN = 0; cycle();
    RSTN = 1;

    // Random instruction stream
    for (int n = 0; n < 500; n++) begin
      clr();
      RSTN        = ($urandom_range(0, 59) != 0);
      IPORT_VALID = ($urandom_range(0, 3) != 0);
      IPORT_DATA  = DW'($urandom);
      ALU_OP      = 3'($urandom);
      INSTR_IMM   = DW'($urandom);
      IMM_SEL     = 1'($urandom);
      LD_SEL      = 1'($urandom);
      LB_IMM      = DW'($urandom);
      BR_COND     = 2'($urandom);
      BR_TARGET   = PW'($urandom);
      REG_ID      = RW'($urandom);
      case ($urandom_range(0, 5))
        0: IS_BR = 1;
        1: IS_LD = 1;
        2: IS_ST = 1;
        3: begin IS_ST = 1; REG_ID = '0; end
        default: ;
      endcase
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
